// File: rtl/aes_s2mm_sts_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_s2mm_sts_gen
// Description : S2MM status generator. Snoops accepted AES result beats,
//               measures each packet's byte count and emits one AXI-DMA
//               status/app packet per data packet. Optional macro
//               AES_STS_TIMESTAMP_EN adds a cycle timestamp as word 1.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_s2mm_sts_gen #(
    parameter int C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
    parameter int C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH                   = 23,
    parameter int C_LEN_FIFO_DEPTH              = 4,
    parameter int C_STS_WORDS                   = 5
) (
    input  logic                                       m_axi_s2mm_aclk,
    input  logic                                       s2mm_prmry_reset_out_n,
    input  logic                                       s_axis_s2mm_tvalid,
    input  logic                                       s_axis_s2mm_tready,
    input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     s_axis_s2mm_tkeep,
    input  logic                                       s_axis_s2mm_tlast,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
    output logic [3:0]                                 s_axis_s2mm_sts_tkeep,
    output logic                                       s_axis_s2mm_sts_tvalid,
    output logic                                       s_axis_s2mm_sts_tlast,
    input  logic                                       s_axis_s2mm_sts_tready,
    output logic                                       sts_stall,
    output logic                                       sts_err_ovf
);

    localparam int c_KEEP_W = C_S_AXIS_S2MM_TDATA_WIDTH / 8;
    localparam int c_PC_W   = $clog2(c_KEEP_W + 1);
    localparam int c_SUM_W  = ((C_LEN_WIDTH > c_PC_W) ? C_LEN_WIDTH : c_PC_W) + 1;
    localparam int c_PTR_W  = $clog2(C_LEN_FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WIDX_W = $clog2(C_STS_WORDS);
`ifdef AES_STS_TIMESTAMP_EN
    localparam int c_TS_W   = 32;
`else
    localparam int c_TS_W   = 0;
`endif
    localparam int c_ENT_W  = C_LEN_WIDTH + 1 + c_TS_W;

    localparam logic [c_SUM_W-1:0]  c_LEN_MAX  = c_SUM_W'((64'd1 << C_LEN_WIDTH) - 64'd1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(C_LEN_FIFO_DEPTH);
    localparam logic [c_WIDX_W-1:0] c_WIDX_LAST = c_WIDX_W'(C_STS_WORDS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic                   w_rst;
    logic [c_PC_W-1:0]      w_pc;
    logic [c_SUM_W-1:0]     w_sum;
    logic                   w_sat_now;
    logic [C_LEN_WIDTH-1:0] w_len_next;
    logic                   w_sat_next;
    logic                   w_beat;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_last_word;
    logic [c_ENT_W-1:0]     w_wr_entry;
    logic [c_ENT_W-1:0]     w_rd_entry;

    logic [C_LEN_WIDTH-1:0] r_acc;
    logic                   r_sat;
    logic [c_ENT_W-1:0]     r_mem [C_LEN_FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_err_ovf;
    logic [0:0]             r_state;
    logic [c_WIDX_W-1:0]    r_widx;

    assign w_rst = ~s2mm_prmry_reset_out_n;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < c_KEEP_W; i++) begin
            w_pc = w_pc + c_PC_W'(s_axis_s2mm_tkeep[i]);
        end
    end

    // Sum in a wider width so saturation can be detected without wrap.
    assign w_sum      = c_SUM_W'(r_acc) + c_SUM_W'(w_pc);
    assign w_sat_now  = (w_sum > c_LEN_MAX);
    assign w_len_next = w_sat_now ? c_LEN_MAX[C_LEN_WIDTH-1:0] : w_sum[C_LEN_WIDTH-1:0];
    assign w_sat_next = r_sat | w_sat_now;

    assign w_beat      = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
    assign w_push_req  = w_beat & s_axis_s2mm_tlast;
    assign w_full      = (r_count == c_CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_last_word = (r_widx == c_WIDX_LAST);
    assign w_pop       = (r_state == c_ST_SEND) & s_axis_s2mm_sts_tready & w_last_word;
    // A same-cycle pop frees the slot, so a push into a full FIFO is still legal.
    assign w_push      = w_push_req & (~w_full | w_pop);

`ifdef AES_STS_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (w_rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    assign w_wr_entry = {r_ts, w_sat_next, w_len_next};
`else
    assign w_wr_entry = {w_sat_next, w_len_next};
`endif

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (w_rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_beat) begin
            if (s_axis_s2mm_tlast) begin
                r_acc <= '0;
                r_sat <= 1'b0;
            end else begin
                r_acc <= w_len_next;
                r_sat <= w_sat_next;
            end
        end
    end

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (w_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req & ~w_push) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (w_rst) begin
            r_state <= c_ST_IDLE;
            r_widx  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_widx  <= '0;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (s_axis_s2mm_sts_tready) begin
                        if (w_last_word) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_widx <= r_widx + c_WIDX_W'(1);
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Head entry stays put while SEND waits on ready, keeping tdata stable.
    assign w_rd_entry = r_mem[r_rd_ptr];

    always_comb begin
        s_axis_s2mm_sts_tdata = '0;
        if (r_state == c_ST_SEND) begin
            if (r_widx == '0) begin
                s_axis_s2mm_sts_tdata =
                    C_S_AXIS_S2MM_STS_TDATA_WIDTH'({4'h5, 27'h0, w_rd_entry[C_LEN_WIDTH]});
`ifdef AES_STS_TIMESTAMP_EN
            end else if (r_widx == c_WIDX_W'(1)) begin
                s_axis_s2mm_sts_tdata =
                    C_S_AXIS_S2MM_STS_TDATA_WIDTH'(w_rd_entry[c_ENT_W-1 -: 32]);
`endif
            end else if (w_last_word) begin
                s_axis_s2mm_sts_tdata =
                    C_S_AXIS_S2MM_STS_TDATA_WIDTH'(w_rd_entry[C_LEN_WIDTH-1:0]);
            end
        end
    end

    assign s_axis_s2mm_sts_tkeep  = 4'hf;
    assign s_axis_s2mm_sts_tvalid = (r_state == c_ST_SEND);
    assign s_axis_s2mm_sts_tlast  = (r_state == c_ST_SEND) & w_last_word;
    assign sts_stall              = w_full;
    assign sts_err_ovf            = r_err_ovf;

endmodule
`default_nettype wire
